// File: rtl/dmem_if.sv
// Request/response bundle between the execute stage and the data memory
// responder. The master drives requests; the slave answers with responses.
interface dmem_if #(
    parameter int DEPTH_LOG2 = 10
);
    logic                  req_valid;
    logic                  req_ready;
    logic [DEPTH_LOG2-1:0] req_addr;
    logic [2:0]            req_offset;
    logic [1:0]            req_size;
    logic                  req_store;
    logic                  req_sext;
    logic [63:0]           req_wdata;
    logic                  rsp_valid;
    logic [63:0]           rsp_data;
    logic                  rsp_err;

    modport master (
        output req_valid, req_addr, req_offset, req_size, req_store, req_sext, req_wdata,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_offset, req_size, req_store, req_sext, req_wdata,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/data_memory_responder.sv
// Data memory responder: one load/store at a time against a 64-bit-wide
// synchronous RAM. Accesses crossing a word boundary take a second beat on
// the next word (wrapping at the top) when DMEM_MISALIGN_SPLIT_EN is defined;
// otherwise the out-of-word bytes are dropped/read as zero and rsp_err flags
// the access.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for a request; response (if any) is visible here
// ACC0  | beat on word addr (read into q0 or masked write)
// ACC1  | beat on word addr+1 for split accesses (split build only)
// DONE  | align/extend load data, register the response
module data_memory_responder #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic   clk,
    input  logic   rstn,
    dmem_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC0 = 2'd1;
    localparam logic [1:0] S_DONE = 2'd3;
`ifdef DMEM_MISALIGN_SPLIT_EN
    localparam logic [1:0] S_ACC1 = 2'd2;
`endif

    logic [1:0]            state_q, state_d;
    logic [DEPTH_LOG2-1:0] addr_q;
    logic [2:0]            offset_q;
    logic [1:0]            size_q;
    logic                  store_q;
    logic                  sext_q;
    logic [63:0]           wdata_q;
    logic [63:0]           q0_q, q1_q;
    logic                  rsp_valid_q;
    logic [63:0]           rsp_data_q;
    logic                  rsp_err_q;

    logic [63:0] mem [DEPTH];

    logic        accept;
    logic [3:0]  bytes;
    logic        split;
    logic        split_err;
    logic [7:0]  byte_mask;
    logic [63:0] st_data_lo;
    logic [7:0]  st_mask_lo;
    logic [63:0] ld_shift;
    logic [63:0] ld_ext;

    assign accept = bus.req_valid && (state_q == S_IDLE);
    assign bytes  = 4'd1 << size_q;
    // offset (max 7) + bytes (max 8) fits in 4 bits
    assign split  = ({1'b0, offset_q} + bytes) > 4'd8;

`ifdef DMEM_MISALIGN_SPLIT_EN
    logic [DEPTH_LOG2-1:0] addr_inc;
    logic [127:0]          st_shift;
    logic [15:0]           st_mask;
    logic [63:0]           st_data_hi;
    logic [7:0]            st_mask_hi;

    assign addr_inc  = addr_q + DEPTH_LOG2'(1);
    assign split_err = 1'b0;

    // Store data and byte mask spread over the two words an access can touch
    always_comb begin
        st_shift   = {64'h0, wdata_q} << {offset_q, 3'b000};
        st_mask    = {8'h00, byte_mask} << offset_q;
        st_data_lo = st_shift[63:0];
        st_data_hi = st_shift[127:64];
        st_mask_lo = st_mask[7:0];
        st_mask_hi = st_mask[15:8];
    end
`else
    assign split_err = split;

    // Store data and byte mask for the single word; bytes past it fall off
    always_comb begin
        st_data_lo = wdata_q << {offset_q, 3'b000};
        st_mask_lo = byte_mask << offset_q;
    end
`endif

    // Byte-enable pattern for the access size, before offset shifting
    always_comb begin
        byte_mask = 8'h00;
        case (size_q)
            2'd0:    byte_mask = 8'h01;
            2'd1:    byte_mask = 8'h03;
            2'd2:    byte_mask = 8'h0F;
            default: byte_mask = 8'hFF;
        endcase
    end

    // Align load bytes down to bit 0, then truncate and sign/zero extend
    always_comb begin
        ld_shift = 64'({q1_q, q0_q} >> {offset_q, 3'b000});
        ld_ext   = '0;
        case (size_q)
            2'd0:    ld_ext = {{56{sext_q & ld_shift[7]}},  ld_shift[7:0]};
            2'd1:    ld_ext = {{48{sext_q & ld_shift[15]}}, ld_shift[15:0]};
            2'd2:    ld_ext = {{32{sext_q & ld_shift[31]}}, ld_shift[31:0]};
            default: ld_ext = ld_shift;
        endcase
    end

    // Sequencing through the beats of one access
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_ACC0;
`ifdef DMEM_MISALIGN_SPLIT_EN
            S_ACC0: state_d = split ? S_ACC1 : S_DONE;
            S_ACC1: state_d = S_DONE;
`else
            S_ACC0: state_d = S_DONE;
`endif
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control state, latched request, load capture and registered response
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            offset_q    <= '0;
            size_q      <= '0;
            store_q     <= 1'b0;
            sext_q      <= 1'b0;
            wdata_q     <= '0;
            q0_q        <= '0;
            q1_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q   <= bus.req_addr;
                offset_q <= bus.req_offset;
                size_q   <= bus.req_size;
                store_q  <= bus.req_store;
                sext_q   <= bus.req_sext;
                wdata_q  <= bus.req_wdata;
            end
            if (state_q == S_ACC0) begin
                q0_q <= mem[addr_q];
                q1_q <= '0;
            end
`ifdef DMEM_MISALIGN_SPLIT_EN
            if (state_q == S_ACC1) begin
                q1_q <= mem[addr_inc];
            end
`endif
            rsp_valid_q <= (state_q == S_DONE);
            rsp_data_q  <= (state_q == S_DONE && !store_q) ? ld_ext : 64'h0;
            rsp_err_q   <= (state_q == S_DONE) && split_err;
        end
    end

    // RAM byte writes; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (state_q == S_ACC0 && store_q) begin
            for (int i = 0; i < 8; i++) begin
                if (st_mask_lo[i]) mem[addr_q][8*i +: 8] <= st_data_lo[8*i +: 8];
            end
        end
`ifdef DMEM_MISALIGN_SPLIT_EN
        if (state_q == S_ACC1 && store_q) begin
            for (int i = 0; i < 8; i++) begin
                if (st_mask_hi[i]) mem[addr_inc][8*i +: 8] <= st_data_hi[8*i +: 8];
            end
        end
`endif
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Memory-side responder for the execute phase's load/store requests. It accepts one request at a time: an 8-byte-word address, a byte offset, an access size, store data and a load/store select. It reads or writes an internal synchronous-read data RAM and returns aligned, extended load data or a store acknowledgement. Accesses whose bytes cross a 64-bit word boundary are split into two RAM beats.

## Interface

Parameters
- DEPTH_LOG2, 10, log2 of RAM depth in 64-bit words.

Ports
- clk  in  1  clock; all state changes on its rising edge.
- rstn  in  1  reset; asynchronous and active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_addr  in  DEPTH_LOG2  64-bit word address.
- req_offset  in  3  byte offset within word (0–7).
- req_size  in  2  access size: 0=1 B, 1=2 B, 2=4 B, 3=8 B.
- req_store  in  1  1=store, 0=load.
- req_sext  in  1  loads only: 1 sign-extends, 0 zero-extends.
- req_wdata  in  64  store data, right-justified (low bytes significant).
- rsp_valid  out  1  one-cycle pulse: load data valid or store complete.
- rsp_data  out  64  aligned, extended load data; 0 for stores.
- rsp_err  out  1  valid with rsp_valid; see Configuration.

## Operation

- An access is accepted on a rising edge where req_valid and req_ready are both 1.
  - All request fields are latched on acceptance.
  - bytes = 1 << req_size.
  - split = (offset + bytes > 8).
- States and transitions:
  - IDLE: req_ready=1. On acceptance, go to ACC0.
  - ACC0: beat on word addr. If split, go to ACC1; otherwise go to DONE.
  - ACC1: beat on word (addr+1) mod 2^DEPTH_LOG2, wrapping past the top word to word 0. Go to DONE.
  - DONE: form the response. Go to IDLE.
- Loads:
  - Each beat registers q0 (or q1) = mem[word] at the end of its cycle.
  - q1 = 0 if not split.
  - Response = ({q1,q0} >> 8*offset) truncated to `bytes` bytes, then sign- or zero-extended to 64 bits.
- Stores:
  - 128-bit shifted data = wdata << 8*offset.
  - 16-bit mask = ((1 << bytes) - 1) << offset.
  - ACC0 writes mask[7:0] bytes of the shifted data's low 64 bits to word addr.
  - ACC1 writes mask[15:8] bytes of the high 64 bits to word addr+1.
  - Bytes outside the mask are unchanged.
- rsp_valid, rsp_data and rsp_err are registered at the end of DONE. They are visible for exactly one cycle, during the following IDLE cycle.
- A new request may be accepted in that same cycle, which gives back-to-back operation.
- Reset values: req_ready=1 (IDLE), rsp_valid=0, rsp_data=0, rsp_err=0, state=IDLE, q0=q1=0. RAM contents are not reset.
- Reset asserted mid-access: immediate return to IDLE.
  - No response is issued.
  - A store's ACC1 beat that has not yet occurred is not performed.
  - An ACC0 write already completed remains in RAM.

## Timing

- Acceptance edge ends cycle 0.
  - Unsplit access: ACC0 in cycle 1, DONE in cycle 2, rsp_valid in cycle 3.
  - Split access: ACC0, ACC1 and DONE in cycles 1–3, rsp_valid in cycle 4.
- req_ready is low in cycles 1 through the DONE cycle and high in the response cycle.
- Maximum throughput: one unsplit access per 3 cycles.
- A load issued in the response cycle of a store to the same word returns the stored data. Stores complete before DONE, so there is no hazard.
- req_valid held without acceptance (ready=0) has no effect. Requesters must hold their fields until acceptance.

## Configuration

- DMEM_MISALIGN_SPLIT_EN defined:
  - Split accesses take the ACC1 beat as described.
  - rsp_err is always 0.
- DMEM_MISALIGN_SPLIT_EN undefined:
  - ACC1 state is not implemented; split accesses go ACC0 → DONE.
  - Load bytes beyond the word read as 0 before extension.
  - Store bytes beyond the word are dropped.
  - rsp_err=1 with rsp_valid for any access where split=1.

## Test plan

- Aligned qword: store addr=5, offset=0, size=3, wdata=0x1122334455667788; then load same, sext=0 → rsp_data=0x1122334455667788. rsp_valid exactly 3 cycles after each acceptance.
- Byte sign extension: memory word 7 = 0x00000000_0000_80_00; load addr=7, offset=1, size=0 → sext=1 gives 0xFFFFFFFFFFFFFF80, sext=0 gives 0x80.
- Split dword with split enabled: store addr=3, offset=6, size=2, wdata=0xAABBCCDD → word3[63:48]=0xCCDD, word4[15:0]=0xAABB, other bytes untouched. Load back with sext=1 → 0xFFFFFFFFAABBCCDD, rsp_valid 4 cycles after acceptance, rsp_err=0.
- Wrap-around: split qword store at addr=2^DEPTH_LOG2-1, offset=4 → upper 4 bytes written to word 0.
- Split disabled: same access as the split-dword scenario → only word3 bytes 6–7 written, word4 unchanged. Load returns 0x000000000000CCDD with rsp_err=1.
- Reset mid-split: assert rstn=0 during ACC1 of a split store → no rsp_valid, req_ready=1 immediately, word4 unchanged. A following aligned load completes normally.
